// File: rtl/ras_pkg.sv
// Shared defaults, types and state encoding for the return-address stack.
package ras_pkg;
  localparam int RAS_ADDR_WIDTH = 12;
  localparam int RAS_DEPTH      = 8;
  localparam int RAS_PTR_W      = $clog2(RAS_DEPTH);

  typedef logic [RAS_ADDR_WIDTH-1:0] ras_addr_t;
  typedef logic [RAS_PTR_W-1:0]      ras_ptr_t;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } ras_state_e;
endpackage

// File: rtl/ras_regfile.sv
// DEPTH x ADDR_WIDTH storage: one synchronous write port, one combinational read port.
module ras_regfile #(
  parameter int ADDR_WIDTH = 12,
  parameter int DEPTH      = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [ADDR_WIDTH-1:0]    wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [ADDR_WIDTH-1:0]    rdata
);
  logic [ADDR_WIDTH-1:0] mem_r [DEPTH];

  // Entry write; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];
endmodule

// File: rtl/return_addr_stack.sv
// Return-address stack: push on JSB, pop on RET, top entry read combinationally.
// Build option: define RAS_WRAP_EN to make a push while full overwrite the oldest entry.
module return_addr_stack
  import ras_pkg::*;
#(
  parameter int ADDR_WIDTH = RAS_ADDR_WIDTH,
  parameter int DEPTH      = RAS_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [ADDR_WIDTH-1:0]    push_addr,
  output logic [ADDR_WIDTH-1:0]    top_addr,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     overflow,
  output logic                     underflow
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [PW-1:0]         sp_r, sp_s;
  logic [CW-1:0]         count_r, count_s;
  ras_state_e            state_r, state_s;
  logic                  overflow_r, overflow_s;
  logic                  underflow_r, underflow_s;
  logic                  we_s;
  logic [PW-1:0]         waddr_s;
  logic [PW-1:0]         top_ptr_s;
  logic [ADDR_WIDTH-1:0] rdata_s;

  assign top_ptr_s = sp_r - PTR_ONE;

  ras_regfile #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_regfile (
    .clk   (clk),
    .we    (we_s),
    .waddr (waddr_s),
    .wdata (push_addr),
    .raddr (top_ptr_s),
    .rdata (rdata_s)
  );

  // Push/pop/replace decode and next-state computation.
  always_comb begin
    we_s        = 1'b0;
    waddr_s     = sp_r;
    sp_s        = sp_r;
    count_s     = count_r;
    overflow_s  = overflow_r;
    underflow_s = underflow_r;
    case ({push, pop})
      2'b10: begin
        if (state_r == FULL) begin
`ifdef RAS_WRAP_EN
          we_s = 1'b1;
          sp_s = sp_r + PTR_ONE;
`else
          overflow_s = 1'b1;
`endif
        end else begin
          we_s    = 1'b1;
          sp_s    = sp_r + PTR_ONE;
          count_s = count_r + CNT_ONE;
        end
      end
      2'b01: begin
        if (state_r == EMPTY) begin
          underflow_s = 1'b1;
        end else begin
          sp_s    = sp_r - PTR_ONE;
          count_s = count_r - CNT_ONE;
        end
      end
      2'b11: begin
        // Replace the top; an empty stack has no top, so this degenerates to a push.
        we_s = 1'b1;
        if (state_r == EMPTY) begin
          sp_s    = sp_r + PTR_ONE;
          count_s = count_r + CNT_ONE;
        end else begin
          waddr_s = top_ptr_s;
        end
      end
      default: begin
        we_s = 1'b0;
      end
    endcase

    if (count_s == CNT_ZERO) begin
      state_s = EMPTY;
    end else if (count_s == CNT_FULL) begin
      state_s = FULL;
    end else begin
      state_s = PARTIAL;
    end
  end

  // Pointer, occupancy, state and sticky flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sp_r        <= {PW{1'b0}};
      count_r     <= CNT_ZERO;
      state_r     <= EMPTY;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      sp_r        <= sp_s;
      count_r     <= count_s;
      state_r     <= state_s;
      overflow_r  <= overflow_s;
      underflow_r <= underflow_s;
    end
  end

  assign top_addr  = (state_r == EMPTY) ? {ADDR_WIDTH{1'b0}} : rdata_s;
  assign count     = count_r;
  assign empty     = (state_r == EMPTY);
  assign full      = (state_r == FULL);
  assign overflow  = overflow_r;
  assign underflow = underflow_r;
endmodule

// File: tb/tb_return_addr_stack.sv
// Self-checking bench for return_addr_stack: queue-based stack model plus directed and random stimulus.
module tb_return_addr_stack;
  localparam int AW    = 12;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          push = 1'b0;
  logic          pop = 1'b0;
  logic [AW-1:0] push_addr = '0;
  logic [AW-1:0] top_addr;
  logic [3:0]    count;
  logic          empty, full, overflow, underflow;

  int n_cmp = 0;
  int n_bad = 0;
  bit started = 1'b0;

  logic [AW-1:0] q[$];
  bit            m_ovf = 1'b0;
  bit            m_unf = 1'b0;

  return_addr_stack #(.ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .push_addr (push_addr),
    .top_addr  (top_addr),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic logic [AW-1:0] m_top();
    return (q.size() > 0) ? q[q.size()-1] : '0;
  endfunction

  // Stack model: a plain LIFO queue with the overflow/underflow rules.
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (push && pop) begin
      if (q.size() > 0) void'(q.pop_back());
      q.push_back(push_addr);
    end else if (push) begin
      if (q.size() == DEPTH) begin
`ifdef RAS_WRAP_EN
        void'(q.pop_front());
        q.push_back(push_addr);
`else
        m_ovf = 1'b1;
`endif
      end else begin
        q.push_back(push_addr);
      end
    end else if (pop) begin
      if (q.size() == 0) m_unf = 1'b1;
      else void'(q.pop_back());
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      chk("top_addr",  32'(top_addr),  32'(m_top()));
      chk("count",     32'(count),     32'(q.size()));
      chk("empty",     32'(empty),     32'(q.size() == 0));
      chk("full",      32'(full),      32'(q.size() == DEPTH));
      chk("overflow",  32'(overflow),  32'(m_ovf));
      chk("underflow", 32'(underflow), 32'(m_unf));
    end
  end

  task automatic cyc(input bit p, input bit o, input logic [AW-1:0] a);
    push = p; pop = o; push_addr = a;
    @(posedge clk); #1;
    push = 1'b0; pop = 1'b0;
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1'b0, 1'b0, '0);
    rst = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    started = 1'b1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_top",   32'(top_addr), 32'h0);
    chk("rst_flags", 32'({overflow, underflow}), 32'd0);

    // Basic push/pop ordering
    cyc(1'b1, 1'b0, 12'h010);
    cyc(1'b1, 1'b0, 12'h020);
    cyc(1'b1, 1'b0, 12'h030);
    chk("t1_count", 32'(count), 32'd3);
    chk("t1_top",   32'(top_addr), 32'h030);
    cyc(1'b0, 1'b1, '0); chk("t1_pop1", 32'(top_addr), 32'h020);
    cyc(1'b0, 1'b1, '0); chk("t1_pop2", 32'(top_addr), 32'h010);
    cyc(1'b0, 1'b1, '0);
    chk("t1_empty", 32'(empty), 32'd1);
    chk("t1_top0",  32'(top_addr), 32'h0);

    // Underflow is sticky until reset
    cyc(1'b0, 1'b1, '0);
    chk("t2_unf",   32'(underflow), 32'd1);
    chk("t2_count", 32'(count), 32'd0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, '0);
    chk("t2_unf_hold", 32'(underflow), 32'd1);
    do_reset();
    chk("t2_unf_clr", 32'(underflow), 32'd0);

    // Fill and push while full
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b0, 12'(12'h100 + i));
    chk("t3_full", 32'(full), 32'd1);
    cyc(1'b1, 1'b0, 12'h1FF);
`ifdef RAS_WRAP_EN
    chk("t3_wtop",   32'(top_addr), 32'h1FF);
    chk("t3_wcount", 32'(count), 32'd8);
    chk("t3_wovf",   32'(overflow), 32'd0);
    begin
      logic [AW-1:0] exp_seq [8] = '{12'h1FF, 12'h107, 12'h106, 12'h105,
                                     12'h104, 12'h103, 12'h102, 12'h101};
      for (int i = 0; i < 8; i++) begin
        chk("t3_wpop", 32'(top_addr), 32'(exp_seq[i]));
        cyc(1'b0, 1'b1, '0);
      end
    end
`else
    chk("t3_ovf", 32'(overflow), 32'd1);
    chk("t3_top", 32'(top_addr), 32'h107);
`endif
    do_reset();

    // Replace the top with a simultaneous push and pop
    cyc(1'b1, 1'b0, 12'h011);
    cyc(1'b1, 1'b0, 12'h055);
    push = 1'b1; pop = 1'b1; push_addr = 12'h0AA;
    #1 chk("t4_incycle", 32'(top_addr), 32'h055);
    @(posedge clk); #1;
    push = 1'b0; pop = 1'b0;
    @(negedge clk); #1;
    chk("t4_top",   32'(top_addr), 32'h0AA);
    chk("t4_count", 32'(count), 32'd2);
    cyc(1'b0, 1'b1, '0);
    chk("t4_second", 32'(top_addr), 32'h011);
    do_reset();

    // Push and pop together on an empty stack
    cyc(1'b1, 1'b1, 12'h033);
    chk("t5_count", 32'(count), 32'd1);
    chk("t5_top",   32'(top_addr), 32'h033);
    chk("t5_unf",   32'(underflow), 32'd0);

    // Reset wins over a simultaneous push
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 12'(12'h040 + i));
    rst = 1'b1;
    cyc(1'b1, 1'b0, 12'h099);
    rst = 1'b0;
    chk("t6_count", 32'(count), 32'd0);
    chk("t6_empty", 32'(empty), 32'd1);
    chk("t6_flags", 32'({overflow, underflow}), 32'd0);
    cyc(1'b1, 1'b0, 12'h077);
    chk("t6_top",   32'(top_addr), 32'h077);
    chk("t6_count1", 32'(count), 32'd1);

    // Random traffic against the model
    for (int i = 0; i < 2000; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), 12'($urandom));
    end
    rst = 1'b0;
    cyc(1'b0, 1'b0, '0);

    started = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
